// File: rtl/corrode_bbox.sv
// Per-frame bounding box and white-pixel population of the erosion stage output.
// The box is published once per completed frame, with a one-cycle o_done pulse.
module corrode_bbox #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int MIN_PIX = 16,
    parameter int CW      = 10
) (
    input  logic          pre_clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic          i_wb,
    input  logic [CW-1:0] i_cnt_x,
    input  logic [CW-1:0] i_cnt_y,
    output logic [CW-1:0] o_x0,
    output logic [CW-1:0] o_x1,
    output logic [CW-1:0] o_y0,
    output logic [CW-1:0] o_y1,
    output logic [18:0]   o_pix_cnt,
    output logic          o_found,
    output logic          o_done,
    output logic          o_abort,
    output logic [1:0]    dbg_state
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] PUBLISH = 2'd2;

    localparam logic [CW:0]   H_LIM   = (CW+1)'(H_ACT);
    localparam logic [CW:0]   V_LIM   = (CW+1)'(V_ACT);
    localparam logic [CW-1:0] X_LAST  = CW'(H_ACT - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(V_ACT - 1);
    localparam logic [18:0]   MIN_CNT = 19'(MIN_PIX);

    logic [1:0]    state;
    logic [CW-1:0] min_x, max_x, min_y, max_y;
    logic [18:0]   cnt;

    logic          accepted, at_origin, at_last, clear, update;
    logic [CW-1:0] base_min_x, base_max_x, base_min_y, base_max_y;
    logic [CW-1:0] nxt_min_x, nxt_max_x, nxt_min_y, nxt_max_y;
    logic [18:0]   base_cnt, nxt_cnt;

    assign dbg_state = state;

    // An accepted (0,0) pixel always starts a fresh frame, whatever the state.
    always_comb begin
        accepted  = i_valid && ({1'b0, i_cnt_x} < H_LIM) && ({1'b0, i_cnt_y} < V_LIM);
        at_origin = (i_cnt_x == '0) && (i_cnt_y == '0);
        at_last   = (i_cnt_x == X_LAST) && (i_cnt_y == Y_LAST);
        clear     = accepted && at_origin;
        update    = accepted && (at_origin || state == ACCUM);

        base_min_x = clear ? '1 : min_x;
        base_max_x = clear ? '0 : max_x;
        base_min_y = clear ? '1 : min_y;
        base_max_y = clear ? '0 : max_y;
        base_cnt   = clear ? '0 : cnt;

        nxt_min_x = (i_wb && i_cnt_x < base_min_x) ? i_cnt_x : base_min_x;
        nxt_max_x = (i_wb && i_cnt_x > base_max_x) ? i_cnt_x : base_max_x;
        nxt_min_y = (i_wb && i_cnt_y < base_min_y) ? i_cnt_y : base_min_y;
        nxt_max_y = (i_wb && i_cnt_y > base_max_y) ? i_cnt_y : base_max_y;
        nxt_cnt   = (i_wb && base_cnt != '1) ? base_cnt + 19'd1 : base_cnt;
    end

    always_ff @(posedge pre_clk) begin
        if (rst) begin
            state     <= IDLE;
            min_x     <= '1;
            max_x     <= '0;
            min_y     <= '1;
            max_y     <= '0;
            cnt       <= '0;
            o_x0      <= '0;
            o_x1      <= '0;
            o_y0      <= '0;
            o_y1      <= '0;
            o_pix_cnt <= '0;
            o_found   <= 1'b0;
            o_done    <= 1'b0;
            o_abort   <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            o_abort <= 1'b0;
            if (update) begin
                min_x <= nxt_min_x;
                max_x <= nxt_max_x;
                min_y <= nxt_min_y;
                max_y <= nxt_max_y;
                cnt   <= nxt_cnt;
            end
            case (state)
                IDLE: begin
                    if (clear) state <= ACCUM;
                end
                ACCUM: begin
                    if (clear) o_abort <= 1'b1;
                    else if (accepted && at_last) state <= PUBLISH;
                end
                PUBLISH: begin
                    // Publishes the pre-clear values even if a new frame starts now.
                    o_pix_cnt <= cnt;
                    o_done    <= 1'b1;
                    if (cnt >= MIN_CNT) begin
                        o_found <= 1'b1;
                        o_x0    <= min_x;
                        o_x1    <= max_x;
                        o_y0    <= min_y;
                        o_y1    <= max_y;
                    end else begin
                        o_found <= 1'b0;
                        o_x0    <= '0;
                        o_x1    <= '0;
                        o_y0    <= '0;
                        o_y1    <= '0;
                    end
                    state <= clear ? ACCUM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_corrode_bbox.sv
// Bench for corrode_bbox: two instances (MIN_PIX=16 and MIN_PIX=1) share one pixel stream;
// expected frame results are queued as frames are sent and checked on each o_done.
module tb_corrode_bbox;
    typedef struct packed {
        logic [9:0]  x0;
        logic [9:0]  x1;
        logic [9:0]  y0;
        logic [9:0]  y1;
        logic [18:0] cnt;
        logic        found;
    } res_t;

    logic       pre_clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_wb = 1'b0;
    logic [9:0] i_cnt_x = '0;
    logic [9:0] i_cnt_y = '0;

    logic [9:0]  n_x0, n_x1, n_y0, n_y1, c_x0, c_x1, c_y0, c_y1;
    logic [18:0] n_cnt, c_cnt;
    logic        n_found, n_done, n_abort, c_found, c_done, c_abort;
    logic [1:0]  n_state, c_state;

    res_t exp_q[$];
    res_t exp_c_q[$];
    int   errors = 0;
    int   checks = 0;
    int   abort_n = 0;
    int   abort_c = 0;
    int   edge_cnt = 0;
    int   last_edge = 0;

    always #5 pre_clk = ~pre_clk;
    always @(posedge pre_clk) edge_cnt <= edge_cnt + 1;

    corrode_bbox #(.MIN_PIX(16)) dut (
        .pre_clk(pre_clk), .rst(rst), .i_valid(i_valid), .i_wb(i_wb),
        .i_cnt_x(i_cnt_x), .i_cnt_y(i_cnt_y),
        .o_x0(n_x0), .o_x1(n_x1), .o_y0(n_y0), .o_y1(n_y1),
        .o_pix_cnt(n_cnt), .o_found(n_found), .o_done(n_done), .o_abort(n_abort),
        .dbg_state(n_state)
    );

    corrode_bbox #(.MIN_PIX(1)) dut_c (
        .pre_clk(pre_clk), .rst(rst), .i_valid(i_valid), .i_wb(i_wb),
        .i_cnt_x(i_cnt_x), .i_cnt_y(i_cnt_y),
        .o_x0(c_x0), .o_x1(c_x1), .o_y0(c_y0), .o_y1(c_y1),
        .o_pix_cnt(c_cnt), .o_found(c_found), .o_done(c_done), .o_abort(c_abort),
        .dbg_state(c_state)
    );

    function automatic logic white_at(input int scen, input int x, input int y);
        case (scen)
            1: return (x >= 100 && x <= 109 && y >= 50 && y <= 59);
            2: return (x == 200 && y == 10) || (x == 205 && y == 20) || (x == 210 && y == 30) ||
                      (x == 202 && y == 400) || (x == 208 && y == 470);
            3: return (x == 0 && y == 0) || (x == 639 && y == 479);
            4: return (x >= 300 && x <= 303 && y >= 300 && y <= 303);
            default: return 1'b0;
        endcase
    endfunction

    // Box values are hand-computed; found and the zeroed box follow from each instance's MIN_PIX.
    task automatic push_exp(input int x0, input int x1, input int y0, input int y1, input int cnt);
        res_t e;
        e.cnt   = 19'(cnt);
        e.found = (cnt >= 16);
        e.x0 = e.found ? 10'(x0) : 10'd0;
        e.x1 = e.found ? 10'(x1) : 10'd0;
        e.y0 = e.found ? 10'(y0) : 10'd0;
        e.y1 = e.found ? 10'(y1) : 10'd0;
        exp_q.push_back(e);
        e.found = (cnt >= 1);
        e.x0 = e.found ? 10'(x0) : 10'd0;
        e.x1 = e.found ? 10'(x1) : 10'd0;
        e.y0 = e.found ? 10'(y0) : 10'd0;
        e.y1 = e.found ? 10'(y1) : 10'd0;
        exp_c_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic wb, input logic [9:0] x, input logic [9:0] y);
        @(negedge pre_clk);
        i_valid = v;
        i_wb    = wb;
        i_cnt_x = x;
        i_cnt_y = y;
        if (v && x == 10'd639 && y == 10'd479) last_edge = edge_cnt + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    // Each row streams column 0, a window around the white area, and column 639;
    // columns outside the window would all be black.
    task automatic send_rows(input int y_a, input int y_b, input int wx0, input int wx1,
                             input int scen, input bit gaps);
        for (int y = y_a; y <= y_b; y++) begin
            for (int c = -1; c <= wx1 - wx0 + 1; c++) begin
                int x;
                x = (c < 0) ? 0 : (c > wx1 - wx0) ? 639 : wx0 + c;
                if (gaps && $urandom_range(0, 3) == 0)
                    drive(1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                          10'($urandom_range(0, 1023)));
                if (gaps && c == 0 && y == 55) drive(1'b1, 1'b1, 10'd700, 10'd55);
                if (gaps && c == 0 && y == 52) drive(1'b1, 1'b1, 10'd105, 10'd500);
                drive(1'b1, white_at(scen, x, y), 10'(x), 10'(y));
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({n_x0, n_x1, n_y0, n_y1, n_cnt, n_found, n_done, n_abort} !== '0) begin
            errors++;
            $display("FAIL %s_n: outputs x0=%0d x1=%0d y0=%0d y1=%0d cnt=%0d found=%0d done=%0d abort=%0d, want all 0",
                     name, n_x0, n_x1, n_y0, n_y1, n_cnt, n_found, n_done, n_abort);
        end
        checks++;
        if ({c_x0, c_x1, c_y0, c_y1, c_cnt, c_found, c_done, c_abort} !== '0) begin
            errors++;
            $display("FAIL %s_c: outputs x0=%0d x1=%0d y0=%0d y1=%0d cnt=%0d found=%0d done=%0d abort=%0d, want all 0",
                     name, c_x0, c_x1, c_y0, c_y1, c_cnt, c_found, c_done, c_abort);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        fork
            begin : monitor
                res_t e, a;
                forever begin
                    @(negedge pre_clk);
                    if (n_done) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL frame_n: unexpected o_done at edge %0d, no frame pending", edge_cnt);
                        end else begin
                            e = exp_q.pop_front();
                            a = {n_x0, n_x1, n_y0, n_y1, n_cnt, n_found};
                            if (a !== e) begin
                                errors++;
                                $display("FAIL frame_n: got box %0d/%0d/%0d/%0d cnt=%0d found=%0d, want %0d/%0d/%0d/%0d cnt=%0d found=%0d",
                                         a.x0, a.x1, a.y0, a.y1, a.cnt, a.found,
                                         e.x0, e.x1, e.y0, e.y1, e.cnt, e.found);
                            end
                        end
                    end
                    if (c_done) begin
                        checks++;
                        if (exp_c_q.size() == 0) begin
                            errors++;
                            $display("FAIL frame_c: unexpected o_done at edge %0d, no frame pending", edge_cnt);
                        end else begin
                            e = exp_c_q.pop_front();
                            a = {c_x0, c_x1, c_y0, c_y1, c_cnt, c_found};
                            if (a !== e) begin
                                errors++;
                                $display("FAIL frame_c: got box %0d/%0d/%0d/%0d cnt=%0d found=%0d, want %0d/%0d/%0d/%0d cnt=%0d found=%0d",
                                         a.x0, a.x1, a.y0, a.y1, a.cnt, a.found,
                                         e.x0, e.x1, e.y0, e.y1, e.cnt, e.found);
                            end
                        end
                        checks++;
                        if (edge_cnt != last_edge + 1) begin
                            errors++;
                            $display("FAIL done_latency: o_done after edge %0d, want edge %0d", edge_cnt, last_edge + 1);
                        end
                    end
                    if (n_abort) abort_n++;
                    if (c_abort) abort_c++;
                end
            end
        join_none

        repeat (3) @(negedge pre_clk);
        check_zero("reset");
        check_int("reset_state", int'(n_state), 0);
        rst = 1'b0;

        push_exp(100, 109, 50, 59, 100);
        send_rows(0, 479, 98, 111, 1, 1'b0);

        push_exp(200, 210, 10, 470, 5);
        send_rows(0, 479, 198, 212, 2, 1'b0);

        push_exp(0, 639, 0, 479, 2);
        send_rows(0, 479, 1, 2, 3, 1'b0);

        send_rows(0, 200, 98, 111, 1, 1'b0);
        push_exp(300, 303, 300, 303, 16);
        send_rows(0, 479, 298, 305, 4, 1'b0);
        idle(5);
        check_int("abort_count_n", abort_n, 1);
        check_int("abort_count_c", abort_c, 1);

        push_exp(100, 109, 50, 59, 100);
        send_rows(0, 479, 98, 111, 1, 1'b1);
        idle(5);

        send_rows(0, 240, 98, 111, 1, 1'b0);
        @(negedge pre_clk);
        rst = 1'b1;
        i_valid = 1'b0;
        @(negedge pre_clk);
        rst = 1'b0;
        check_zero("mid_reset");
        check_int("mid_reset_state", int'(c_state), 0);
        send_rows(241, 479, 98, 111, 1, 1'b0);
        idle(3);
        push_exp(100, 109, 50, 59, 100);
        send_rows(0, 479, 98, 111, 1, 1'b0);
        idle(10);

        check_int("pending_n", exp_q.size(), 0);
        check_int("pending_c", exp_c_q.size(), 0);
        check_int("abort_total_n", abort_n, 1);
        check_int("abort_total_c", abort_c, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
